pool2d_unit: RTL and testbench
==============================

// Module: pool2d_unit
// PURPOSE
//  Generalised 2D pooling stage behind the requant units: collects SA_N int8 samples/cycle into an
//  SA_N x SA_N scratch tile, detects complete FILTER_H x FILTER_W blocks, and reduces each by MAX or
//  AVG (runtime mode). Results queue in an output FIFO with valid/ready backpressure toward the
//  output writer. Reports idle and a sticky overwrite error.
// PARAMETERS
//  SA_N        4                 tile dimension; lanes per cycle (= STA columns)
//  MAX_N       512               max feature-map dimension
//  N_BITS      $clog2(MAX_N+1)   coordinate width
//  FILTER_H    2                 window height; power of 2, divides SA_N
//  FILTER_W    2                 window width; power of 2, divides SA_N
//  FIFO_DEPTH  4                 output FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1              clock
//  reset      in   1              asynchronous, active-high
//  mode       in   1              0 = MAX, 1 = AVG; stable while idle=0
//  pos_row    in   N_BITS         tile base row (input coords, multiple of FILTER_H)
//  pos_col    in   N_BITS         tile base col (input coords, multiple of FILTER_W)
//  in_valid   in   [SA_N]x1       lane sample valid
//  in_row     in   [SA_N]xN_BITS  lane sample row (input coords)
//  in_col     in   [SA_N]xN_BITS  lane sample col (input coords)
//  in_data    in   [SA_N]x8       lane sample, signed int8
//  in_ready   out  1              advisory: FIFO has >=1 free entry
//  out_valid  out  1              FIFO head valid
//  out_ready  in   1              consumer accepts head
//  out_row    out  N_BITS         pooled row (output coords)
//  out_col    out  N_BITS         pooled col (output coords)
//  out_data   out  8              pooled value, signed int8
//  idle       out  1              no pending samples and FIFO empty
//  err_ovwr   out  1              sticky: sample hit an already-valid scratch cell
// BEHAVIOUR
//  Reset: valid_map all 0, FIFO empty, out_valid=0, out_row/col/data=0, err_ovwr=0, in_ready=1, idle=1.
//  Write: per lane with in_valid, cell (in_row-pos_row, in_col-pos_col) truncated to $clog2(SA_N) bits
//   stores data, sets valid. Cell already valid and not cleared this cycle -> err_ovwr<=1 (data still
//   written). Two lanes same cell same cycle: higher lane index wins, err_ovwr<=1.
//  Scan (comb, from registered valid_map): first complete block in row-major block order (blk_r,blk_c).
//  Emit: if block found and FIFO not full -> clear its cells, push {row,col,data}. FIFO full -> block
//   stays valid, retried every cycle; no data loss. At most one block emitted per cycle.
//  Same-cycle write to a cell being cleared: write wins (cell ends valid, no err_ovwr).
//  MAX: signed max over window.
//  AVG: S = signed sum (width 8+log2(FILTER_H*FILTER_W)); data = (S + K/2) >>> log2(K), K=FILTER_H*FILTER_W
//   (round half toward +inf); result always fits int8, no saturation needed.
//  Coords: out_row = (pos_row>>log2 FILTER_H) + blk_r; out_col = (pos_col>>log2 FILTER_W) + blk_c.
//  Latency: last sample of block at edge t -> pushed at edge t+1 -> out_valid=1 after edge t+1
//   (FIFO empty, no earlier-ordered ready block).
//  FIFO: first-word-fall-through; pop on out_valid&&out_ready; push+pop same cycle when full allowed
//   (count unchanged). in_ready = (count<FIFO_DEPTH) registered-count based.
//  idle = ~|valid_map & (count==0).
//  Reset mid-operation: all pending samples and FIFO contents discarded; err_ovwr cleared.
//  mode change while idle=0 is illegal (result undefined, no error flag).
// TESTING
//  MAX, 2x2 at pos(0,0): cells {5,-3,7,2} over 2 cycles -> out (0,0) data 7, 2 cycles after last sample.
//  AVG: {1,2,3,4} -> 3; {-1,-2,-2,-2} -> -2; {-128 x4} -> -128; {127 x4} -> 127.
//  Full 4x4 tile in one block-row order at pos(4,8) -> outputs (2,4),(2,5),(3,4),(3,5) in order.
//  out_ready=0, 6 blocks ready -> 4 queued, in_ready=0, 2 held in scratch; release -> all 6, order kept.
//  Rewrite valid cell (1,1) -> err_ovwr=1 sticky; same-cycle clear+write of a cell -> no error, cell valid.
//  reset asserted with 3 FIFO entries + partial block -> next cycle out_valid=0, idle=1, err_ovwr=0.

Source files
------------

// File: rtl/pool2d_unit_if.sv
// Stream bundle for pool2d_unit: SA_N-lane sample input and the pooled output queue.
interface pool2d_unit_if #(
    parameter int SA_N   = 4,
    parameter int N_BITS = 10
);
    logic [SA_N-1:0]              in_valid;
    logic [SA_N-1:0][N_BITS-1:0]  in_row;
    logic [SA_N-1:0][N_BITS-1:0]  in_col;
    logic [SA_N-1:0][7:0]         in_data;
    logic                         in_ready;
    logic                         out_valid;
    logic                         out_ready;
    logic [N_BITS-1:0]            out_row;
    logic [N_BITS-1:0]            out_col;
    logic [7:0]                   out_data;

    // Producer of samples / consumer of pooled results
    modport master (
        output in_valid, in_row, in_col, in_data, out_ready,
        input  in_ready, out_valid, out_row, out_col, out_data
    );

    // The pooling unit itself
    modport slave (
        input  in_valid, in_row, in_col, in_data, out_ready,
        output in_ready, out_valid, out_row, out_col, out_data
    );
endinterface

// File: rtl/pool2d_unit.sv
// 2D pooling stage: SA_N lanes of int8 samples land in an SA_N x SA_N scratch tile;
// each complete FILTER_H x FILTER_W block is reduced (MAX or rounded AVG) and
// queued in a first-word-fall-through output FIFO.
module pool2d_unit #(
    parameter int SA_N       = 4,
    parameter int MAX_N      = 512,
    parameter int N_BITS     = $clog2(MAX_N + 1),
    parameter int FILTER_H   = 2,
    parameter int FILTER_W   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_mode,
    input  logic [N_BITS-1:0] i_pos_row,
    input  logic [N_BITS-1:0] i_pos_col,
    pool2d_unit_if.slave      bus,
    output logic              o_idle,
    output logic              o_err_ovwr
);
    localparam int LOG_N  = $clog2(SA_N);
    localparam int NCELL  = SA_N * SA_N;
    localparam int CELL_W = $clog2(NCELL);
    localparam int NB_R   = SA_N / FILTER_H;
    localparam int NB_C   = SA_N / FILTER_W;
    localparam int K      = FILTER_H * FILTER_W;
    localparam int LOG_K  = $clog2(K);
    localparam int LOG_FH = $clog2(FILTER_H);
    localparam int LOG_FW = $clog2(FILTER_W);
    localparam int SUM_W  = 8 + LOG_K;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    // Scratch tile: one valid bit and one sample per cell, row-major
    logic [NCELL-1:0]        r_valid_map;
    logic signed [7:0]       r_cell [NCELL];
    logic                    r_err_ovwr;

    // Output FIFO
    logic [N_BITS-1:0]       r_fifo_row  [FIFO_DEPTH];
    logic [N_BITS-1:0]       r_fifo_col  [FIFO_DEPTH];
    logic [7:0]              r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wptr;
    logic [PTR_W-1:0]        r_rptr;
    logic [CNT_W-1:0]        r_count;

    logic [SA_N-1:0][LOG_N-1:0] w_lane_r;
    logic [SA_N-1:0][LOG_N-1:0] w_lane_c;
    logic [NCELL-1:0]        w_hit;
    logic [NCELL-1:0]        w_multi;
    logic [NCELL-1:0]        w_clear;
    logic signed [7:0]       w_wdata [NCELL];
    logic                    w_found;
    logic [N_BITS-1:0]       w_blk_r;
    logic [N_BITS-1:0]       w_blk_c;
    logic signed [7:0]       w_max;
    logic signed [7:0]       w_avg;
    logic [7:0]              w_result;
    logic                    w_out_valid;
    logic                    w_push;
    logic                    w_pop;

    genvar gi;

    // Tile-relative cell address of each lane (wraps within the tile)
    generate
        for (gi = 0; gi < SA_N; gi++) begin : g_lane
            assign w_lane_r[gi] = LOG_N'(bus.in_row[gi] - i_pos_row);
            assign w_lane_c[gi] = LOG_N'(bus.in_col[gi] - i_pos_col);
        end
    endgenerate

    generate
        for (gi = 0; gi < NCELL; gi++) begin : g_cell
            localparam logic [LOG_N-1:0] CR = LOG_N'(gi / SA_N);
            localparam logic [LOG_N-1:0] CC = LOG_N'(gi % SA_N);
            localparam int BR = (gi / SA_N) / FILTER_H;
            localparam int BC = (gi % SA_N) / FILTER_W;
            logic              l_hit;
            logic              l_multi;
            logic signed [7:0] l_wdata;

            // Lane decode for this cell; the highest matching lane index wins
            always_comb begin
                l_hit   = 1'b0;
                l_multi = 1'b0;
                l_wdata = '0;
                for (int l = 0; l < SA_N; l++) begin
                    if (bus.in_valid[l] && (w_lane_r[l] == CR) && (w_lane_c[l] == CC)) begin
                        l_multi = l_multi | l_hit;
                        l_hit   = 1'b1;
                        l_wdata = bus.in_data[l];
                    end
                end
            end

            assign w_hit[gi]   = l_hit;
            assign w_multi[gi] = l_multi;
            assign w_wdata[gi] = l_wdata;
            assign w_clear[gi] = w_push && (w_blk_r == N_BITS'(BR)) && (w_blk_c == N_BITS'(BC));
        end
    endgenerate

    // Find the first complete block in row-major order (reverse scan, last hit wins)
    always_comb begin
        logic l_full;
        l_full  = 1'b0;
        w_found = 1'b0;
        w_blk_r = '0;
        w_blk_c = '0;
        for (int br = NB_R - 1; br >= 0; br--) begin
            for (int bc = NB_C - 1; bc >= 0; bc--) begin
                l_full = 1'b1;
                for (int i = 0; i < FILTER_H; i++) begin
                    for (int j = 0; j < FILTER_W; j++) begin
                        l_full = l_full &
                            r_valid_map[CELL_W'((br * FILTER_H + i) * SA_N + bc * FILTER_W + j)];
                    end
                end
                if (l_full) begin
                    w_found = 1'b1;
                    w_blk_r = N_BITS'(br);
                    w_blk_c = N_BITS'(bc);
                end
            end
        end
    end

    // Reduce the selected window: signed max and round-half-up average
    always_comb begin
        logic signed [7:0]       l_val;
        logic signed [SUM_W-1:0] l_sum;
        logic signed [SUM_W-1:0] l_rnd;
        l_val = '0;
        l_sum = '0;
        w_max = 8'sh80;
        for (int i = 0; i < FILTER_H; i++) begin
            for (int j = 0; j < FILTER_W; j++) begin
                l_val = r_cell[CELL_W'((int'(w_blk_r) * FILTER_H + i) * SA_N
                                       + int'(w_blk_c) * FILTER_W + j)];
                if (l_val > w_max) w_max = l_val;
                l_sum = l_sum + SUM_W'(l_val);
            end
        end
        l_rnd = l_sum + SUM_W'(K / 2);
        w_avg = 8'(l_rnd >>> LOG_K);
    end

    assign w_result    = i_mode ? w_avg : w_max;
    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid && bus.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts a push
    assign w_push      = w_found && ((r_count != CNT_W'(FIFO_DEPTH)) || w_pop);

    // Scratch valid map and sticky overwrite flag; a same-cycle write beats the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_map <= '0;
            r_err_ovwr  <= 1'b0;
        end else begin
            r_valid_map <= w_hit | (r_valid_map & ~w_clear);
            if ((|(w_hit & r_valid_map & ~w_clear)) || (|w_multi))
                r_err_ovwr <= 1'b1;
        end
    end

    // Scratch sample storage
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCELL; i++) begin
            if (w_hit[i]) r_cell[i] <= w_wdata[i];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO payload storage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_row[r_wptr]  <= (i_pos_row >> LOG_FH) + w_blk_r;
            r_fifo_col[r_wptr]  <= (i_pos_col >> LOG_FW) + w_blk_c;
            r_fifo_data[r_wptr] <= w_result;
        end
    end

    assign bus.out_valid = w_out_valid;
    assign bus.out_row   = w_out_valid ? r_fifo_row[r_rptr]  : '0;
    assign bus.out_col   = w_out_valid ? r_fifo_col[r_rptr]  : '0;
    assign bus.out_data  = w_out_valid ? r_fifo_data[r_rptr] : '0;
    assign bus.in_ready  = (r_count != CNT_W'(FIFO_DEPTH));
    assign o_idle        = ~|r_valid_map && (r_count == '0);
    assign o_err_ovwr    = r_err_ovwr;
endmodule

// File: tb/tb_pool2d_unit.sv
// Directed self-checking bench for pool2d_unit (SA_N=4, 2x2 windows, 4-entry FIFO).
module tb_pool2d_unit;
    localparam int N_BITS = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              mode = 1'b0;
    logic [N_BITS-1:0] pos_row = '0;
    logic [N_BITS-1:0] pos_col = '0;
    logic              idle;
    logic              err_ovwr;
    int                checks = 0;
    int                errors = 0;

    pool2d_unit_if #(.SA_N(4), .N_BITS(N_BITS)) bus ();

    pool2d_unit #(
        .SA_N(4), .MAX_N(512), .N_BITS(N_BITS),
        .FILTER_H(2), .FILTER_W(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .i_mode(mode),
        .i_pos_row(pos_row), .i_pos_col(pos_col),
        .bus(bus), .o_idle(idle), .o_err_ovwr(err_ovwr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_lanes();
        bus.in_valid = '0;
    endtask

    task automatic set_lane(input int l, input int r, input int c, input int d);
        bus.in_valid[l] = 1'b1;
        bus.in_row[l]   = N_BITS'(r);
        bus.in_col[l]   = N_BITS'(c);
        bus.in_data[l]  = 8'(d);
    endtask

    // Write one complete 2x2 block (absolute coords, top-left r0,c0) in a single cycle
    task automatic put4(input int r0, input int c0, input int d0, input int d1,
                        input int d2, input int d3);
        set_lane(0, r0,     c0,     d0);
        set_lane(1, r0,     c0 + 1, d1);
        set_lane(2, r0 + 1, c0,     d2);
        set_lane(3, r0 + 1, c0 + 1, d3);
        step();
        clr_lanes();
    endtask

    // Wait (bounded) for the FIFO head, check it, then pop it
    task automatic expect_out(input string tag, input int row, input int col, input int data);
        int n;
        logic [7:0] exp_d;
        n = 0;
        exp_d = 8'(data);
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
        chk({tag, "_row"}, {22'b0, bus.out_row}, 32'(row));
        chk({tag, "_col"}, {22'b0, bus.out_col}, 32'(col));
        chk({tag, "_data"}, {24'b0, bus.out_data}, {24'b0, exp_d});
        $display("pop %s row=%0d col=%0d data=%0d", tag, bus.out_row, bus.out_col,
                 $signed(bus.out_data));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = '0;
        bus.in_row    = '0;
        bus.in_col    = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset state
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_idle", {31'b0, idle}, 32'd1);
        chk("rst_err", {31'b0, err_ovwr}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_out_row", {22'b0, bus.out_row}, 32'd0);
        chk("rst_out_data", {24'b0, bus.out_data}, 32'd0);

        // MAX over two cycles, latency check
        mode = 1'b0; pos_row = '0; pos_col = '0;
        set_lane(0, 0, 0, 5); set_lane(1, 0, 1, -3);
        step(); clr_lanes();
        set_lane(0, 1, 0, 7); set_lane(1, 1, 1, 2);
        step(); clr_lanes();
        chk("lat_t", {31'b0, bus.out_valid}, 32'd0);
        step();
        chk("lat_t1", {31'b0, bus.out_valid}, 32'd1);
        expect_out("max0", 0, 0, 7);
        put4(0, 0, -5, -3, -100, -4);
        expect_out("max_neg", 0, 0, -3);

        // AVG with rounding and extremes
        mode = 1'b1;
        put4(0, 0, 1, 2, 3, 4);         expect_out("avg_1234", 0, 0, 3);
        put4(0, 0, -1, -2, -2, -2);     expect_out("avg_neg", 0, 0, -2);
        put4(0, 0, -128, -128, -128, -128); expect_out("avg_min", 0, 0, -128);
        put4(0, 0, 127, 127, 127, 127); expect_out("avg_max", 0, 0, 127);
        mode = 1'b0;

        // Full tile at pos(4,8), one row per cycle
        pos_row = N_BITS'(4); pos_col = N_BITS'(8);
        for (int r = 0; r < 4; r++) begin
            for (int l = 0; l < 4; l++) set_lane(l, 4 + r, 8 + l, r * 4 + l);
            step(); clr_lanes();
        end
        expect_out("tile_a", 2, 4, 5);
        expect_out("tile_b", 2, 5, 7);
        expect_out("tile_c", 3, 4, 13);
        expect_out("tile_d", 3, 5, 15);

        // Backpressure: 4 blocks fill the FIFO, 2 more wait in scratch
        pos_row = '0; pos_col = '0;
        for (int r = 0; r < 4; r++) begin
            for (int l = 0; l < 4; l++) set_lane(l, r, l, 20 + r * 4 + l);
            step(); clr_lanes();
        end
        repeat (6) step();
        chk("bp_full_in_ready", {31'b0, bus.in_ready}, 32'd0);
        for (int r = 0; r < 2; r++) begin
            for (int l = 0; l < 4; l++) set_lane(l, r, l, -(r * 4 + l + 1));
            step(); clr_lanes();
        end
        repeat (3) step();
        chk("bp_held_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("bp_held_idle", {31'b0, idle}, 32'd0);
        chk("bp_err", {31'b0, err_ovwr}, 32'd0);
        expect_out("bp0", 0, 0, 25);
        expect_out("bp1", 0, 1, 27);
        expect_out("bp2", 1, 0, 33);
        expect_out("bp3", 1, 1, 35);
        expect_out("bp4", 0, 0, -1);
        expect_out("bp5", 0, 1, -3);
        chk("bp_drained_idle", {31'b0, idle}, 32'd1);

        // Same-cycle clear and write of cell (0,0): no error, cell stays valid
        put4(0, 0, 1, 1, 1, 9);
        set_lane(0, 0, 0, 50);
        step(); clr_lanes();
        chk("cw_err", {31'b0, err_ovwr}, 32'd0);
        expect_out("cw", 0, 0, 9);
        chk("cw_cell_valid", {31'b0, idle}, 32'd0);

        // Rewrite of valid cell (1,1) raises the sticky error
        set_lane(0, 1, 1, 3);
        step(); clr_lanes();
        chk("ovwr_first", {31'b0, err_ovwr}, 32'd0);
        set_lane(0, 1, 1, 4);
        step(); clr_lanes();
        chk("ovwr_set", {31'b0, err_ovwr}, 32'd1);
        repeat (2) step();
        chk("ovwr_sticky", {31'b0, err_ovwr}, 32'd1);

        // Reset with 3 queued results plus a partial block
        put4(0, 2, 1, 2, 3, 4);
        put4(2, 0, 1, 2, 3, 4);
        put4(2, 2, 1, 2, 3, 4);
        repeat (2) step();
        chk("pre_rst_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("pre_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("pre_rst_idle", {31'b0, idle}, 32'd0);
        reset = 1'b1;
        step();
        chk("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mid_rst_idle", {31'b0, idle}, 32'd1);
        chk("mid_rst_err", {31'b0, err_ovwr}, 32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("post_rst_idle", {31'b0, idle}, 32'd1);
        chk("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
